// File: rtl/ws2812b_pkg.sv
// ----------------------------------------------------------------------------
// ws2812b_pkg
// Shared definitions for the WS2812B transmitter and its matching receiver.
// Holds the encoder state enum, the default waveform timing (in 64 MHz clock
// cycles) and the receiver's decode threshold / idle time, so both ends of
// the link are derived from one place.
// No ports (package).
// ----------------------------------------------------------------------------
package ws2812b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } ws_state_e;

  localparam int unsigned CLK_HZ_DEF         = 64_000_000;
  localparam int unsigned T0H_CYCLES_DEF     = 26;    // ~0.41 us
  localparam int unsigned T1H_CYCLES_DEF     = 51;    // ~0.80 us
  localparam int unsigned BIT_CYCLES_DEF     = 80;    // 1.25 us
  localparam int unsigned RESET_CYCLES_DEF   = 4480;  // 70 us latch

  // Receiver side: high pulses longer than the threshold decode as '1', and
  // a low period longer than the idle time ends a frame.
  localparam int unsigned DEC_THRESHOLD_CYCLES = 38;
  localparam int unsigned DEC_IDLE_US          = 60;
  localparam int unsigned DEC_IDLE_CYCLES      = DEC_IDLE_US * (CLK_HZ_DEF / 1_000_000);

endpackage

// File: rtl/ws2812b_pixel_encoder_if.sv
// ----------------------------------------------------------------------------
// ws2812b_pixel_encoder_if
// Pixel stream into the WS2812B encoder.
//   pixel_valid : source offers pixel_data
//   pixel_ready : encoder can take a pixel this cycle
//   pixel_data  : [23:16]=G, [15:8]=R, [7:0]=B
// Handshake: a transfer happens on every rising clock edge where both
// pixel_valid and pixel_ready are high; pixel_data is sampled only on that
// edge. While pixel_ready is low the source may change or drop pixel_valid
// and pixel_data freely; nothing is taken.
// ----------------------------------------------------------------------------
interface ws2812b_pixel_encoder_if;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [23:0] pixel_data;

  modport master (output pixel_valid, output pixel_data, input pixel_ready);
  modport slave  (input pixel_valid, input pixel_data, output pixel_ready);
endinterface

// File: rtl/ws2812b_pixel_encoder.sv
// ----------------------------------------------------------------------------
// ws2812b_pixel_encoder
// Serialises 24-bit GRB pixels MSB first onto a WS2812B NRZ line. Each bit is
// BIT_CYCLES long with a high time of T0H_CYCLES or T1H_CYCLES. Pixels that
// arrive on the last cycle of the previous pixel follow with no gap; after the
// last pixel the line is held low for RESET_CYCLES to latch the LED chain.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   pix         : pixel stream (slave side of ws2812b_pixel_encoder_if)
//   dout        : registered serial output
//   busy        : high whenever the FSM is not IDLE
//   frame_done  : one-cycle pulse on the last latch cycle
//   dbg_state   : current FSM state
// ----------------------------------------------------------------------------
module ws2812b_pixel_encoder
  import ws2812b_pkg::*;
#(
  parameter int unsigned CLK_HZ       = CLK_HZ_DEF,
  parameter int unsigned T0H_CYCLES   = T0H_CYCLES_DEF,
  parameter int unsigned T1H_CYCLES   = T1H_CYCLES_DEF,
  parameter int unsigned BIT_CYCLES   = BIT_CYCLES_DEF,
  parameter int unsigned RESET_CYCLES = RESET_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ws2812b_pixel_encoder_if.slave  pix,
  output logic                    dout,
  output logic                    busy,
  output logic                    frame_done,
  output ws_state_e               dbg_state
);

  if (!(T0H_CYCLES >= 1 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_timing
    $error("ws2812b_pixel_encoder: need 1 <= T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
  end
  if (CLK_HZ == 0 || RESET_CYCLES == 0) begin : g_bad_clk
    $error("ws2812b_pixel_encoder: CLK_HZ and RESET_CYCLES must be non-zero");
  end

  // One down-counter serves every phase; it is loaded with (length - 1) on
  // entry and the phase ends on the cycle it reads zero.
  localparam int unsigned CW = $clog2(RESET_CYCLES + 1);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t T0H_M1 = cnt_t'(T0H_CYCLES - 1);
  localparam cnt_t T1H_M1 = cnt_t'(T1H_CYCLES - 1);
  localparam cnt_t T0L_M1 = cnt_t'(BIT_CYCLES - T0H_CYCLES - 1);
  localparam cnt_t T1L_M1 = cnt_t'(BIT_CYCLES - T1H_CYCLES - 1);
  localparam cnt_t RST_M1 = cnt_t'(RESET_CYCLES - 1);

  ws_state_e   state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [23:0] shift_q, shift_d;
  logic        dout_q, dout_d;

  logic last_cycle;
  logic ready_c;
  logic take;

  assign last_cycle = (cnt_q == '0);
  // Ready in IDLE, and on the final LOW cycle of bit 0 so the next pixel can
  // chain on without a gap.
  assign ready_c = (state_q == ST_IDLE) ||
                   (state_q == ST_LOW && last_cycle && idx_q == 5'd0);
  assign take    = ready_c & pix.pixel_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    if (take) begin
      state_d = ST_HIGH;
      shift_d = pix.pixel_data;
      idx_d   = 5'd23;
      cnt_d   = pix.pixel_data[23] ? T1H_M1 : T0H_M1;
    end else begin
      case (state_q)
        ST_HIGH: begin
          if (last_cycle) begin
            state_d = ST_LOW;
            cnt_d   = shift_q[23] ? T1L_M1 : T0L_M1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_LOW: begin
          if (!last_cycle) begin
            cnt_d = cnt_q - 1'b1;
          end else if (idx_q != 5'd0) begin
            // Bit 22 becomes the new MSB, so it selects the next high time.
            shift_d = {shift_q[22:0], 1'b0};
            idx_d   = idx_q - 5'd1;
            state_d = ST_HIGH;
            cnt_d   = shift_q[22] ? T1H_M1 : T0H_M1;
          end else begin
            state_d = ST_LATCH;
            cnt_d   = RST_M1;
          end
        end
        ST_LATCH: begin
          if (last_cycle) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
    // Registering the next-state decode keeps dout aligned with state_q.
    dout_d = (state_d == ST_HIGH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 5'd0;
      shift_q <= 24'd0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
    end
  end

  assign pix.pixel_ready = ready_c & rst_n;
  assign dout            = dout_q;
  assign busy            = (state_q != ST_IDLE);
  assign frame_done      = (state_q == ST_LATCH) && last_cycle;
  assign dbg_state       = state_q;

endmodule
